// File: rtl/seq_mult4_pkg.sv
// Shared definitions for the sequential 4x4 shift-and-add multiplier.
package seq_mult4_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int         ITERS     = 4;
    localparam logic [1:0] LAST_ITER = 2'(ITERS - 1);

endpackage : seq_mult4_pkg

// File: rtl/seq_mult4_add4.sv
// 4-bit ripple-carry adder: s = a + b + cin, carry out on cout.
module add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bit
            assign s[gi]         = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[4];

endmodule : add4

// File: rtl/seq_mult4.sv
// Sequential 4x4 unsigned multiplier: one shared 4-bit adder, four shift-and-add
// iterations, start/busy/done handshake and a registered 8-bit product.
module seq_mult4
    import seq_mult4_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] product
);

    state_t     state_reg, state_next;
    logic [3:0] m_reg, m_next;
    logic [3:0] acc_reg, acc_next;
    logic [3:0] q_reg, q_next;
    logic [1:0] cnt_reg, cnt_next;
    logic [7:0] product_reg, product_next;

    logic [3:0] addend;
    logic [3:0] sum;
    logic       carry;
    logic [3:0] acc_shift;
    logic [3:0] q_shift;

    // The multiplicand is added only when the current multiplier LSB is set.
    assign addend = q_reg[0] ? m_reg : 4'd0;

    add4 u_add4 (
        .a    (acc_reg),
        .b    (addend),
        .cin  (1'b0),
        .s    (sum),
        .cout (carry)
    );

    // {carry, sum, q} shifted right by one: sum LSB drops into the lower product.
    assign acc_shift = {carry, sum[3:1]};
    assign q_shift   = {sum[0], q_reg[3:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            m_reg       <= 4'd0;
            acc_reg     <= 4'd0;
            q_reg       <= 4'd0;
            cnt_reg     <= 2'd0;
            product_reg <= 8'd0;
        end else begin
            state_reg   <= state_next;
            m_reg       <= m_next;
            acc_reg     <= acc_next;
            q_reg       <= q_next;
            cnt_reg     <= cnt_next;
            product_reg <= product_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        m_next       = m_reg;
        acc_next     = acc_reg;
        q_next       = q_reg;
        cnt_next     = cnt_reg;
        product_next = product_reg;

        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    m_next     = a;
                    q_next     = b;
                    acc_next   = 4'd0;
                    cnt_next   = 2'd0;
                    state_next = RUN;
                end
            end
            RUN: begin
                acc_next = acc_shift;
                q_next   = q_shift;
                cnt_next = cnt_reg + 2'd1;
                if (cnt_reg == LAST_ITER) begin
                    product_next = {acc_shift, q_shift};
                    state_next   = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy    = (state_reg != IDLE);
    assign done    = (state_reg == DONE);
    assign product = product_reg;

endmodule : seq_mult4

// File: tb/tb_seq_mult4.sv
// Directed self-checking bench for seq_mult4: handshake timing, products,
// start-ignore during RUN, asynchronous reset and a back-to-back exhaustive sweep.
module tb_seq_mult4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int checks = 0;
    int errors = 0;

    seq_mult4 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one multiply from IDLE (called on a negedge) and check the full
    // handshake: busy for 5 cycles, single done 4 cycles after accept, product holds.
    task automatic run_mult(input string tag, input logic [3:0] av, input logic [3:0] bv,
                            input logic [7:0] exp);
        int busy_cycles;
        int done_cycles;
        a = av;
        b = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_cycles = (busy === 1'b1) ? 1 : 0;
        done_cycles = (done === 1'b1) ? 1 : 0;
        check({tag, "_busy_after_accept"}, {7'd0, busy}, 8'd1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cycles++;
            if (done === 1'b1) done_cycles++;
            check({tag, "_done_timing"}, {7'd0, done}, (k == 4) ? 8'd1 : 8'd0);
        end
        check({tag, "_product"}, product, exp);
        @(negedge clk);
        if (busy === 1'b1) busy_cycles++;
        if (done === 1'b1) done_cycles++;
        check({tag, "_busy_cycles"}, 8'(busy_cycles), 8'd5);
        check({tag, "_done_count"}, 8'(done_cycles), 8'd1);
        check({tag, "_product_hold"}, product, exp);
        $display("txn %s a=%0d b=%0d product=%0h expected=%0h", tag, av, bv, product, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = 4'd0;
        b     = 4'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("reset_product", product, 8'h00);
        check("reset_busy", {7'd0, busy}, 8'd0);
        check("reset_done", {7'd0, done}, 8'd0);
        @(negedge clk);
        check("idle_no_start_busy", {7'd0, busy}, 8'd0);

        run_mult("zero", 4'h0, 4'h0, 8'h00);
        run_mult("max", 4'hF, 4'hF, 8'hE1);
        @(negedge clk);
        check("max_hold_idle", product, 8'hE1);
        run_mult("m9x6", 4'h9, 4'h6, 8'h36);
        run_mult("m6x9", 4'h6, 4'h9, 8'h36);
        run_mult("m1x8", 4'h1, 4'h8, 8'h08);

        // Start pulse and operand changes during RUN must not disturb the result.
        a = 4'h3;
        b = 4'h5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 4'hF;
        b = 4'hF;
        @(negedge clk);
        start = 1'b1;
        check("ign_done_run1", {7'd0, done}, 8'd0);
        @(negedge clk);
        start = 1'b0;
        check("ign_done_run2", {7'd0, done}, 8'd0);
        @(negedge clk);
        check("ign_done_run3", {7'd0, done}, 8'd0);
        @(negedge clk);
        check("ign_done", {7'd0, done}, 8'd1);
        check("ign_product", product, 8'h0F);
        @(negedge clk);
        check("ign_done_fall", {7'd0, done}, 8'd0);
        check("ign_busy_fall", {7'd0, busy}, 8'd0);
        @(negedge clk);
        check("ign_no_restart", {7'd0, busy}, 8'd0);
        $display("txn ignore a=3 b=5 product=%0h expected=0f", product);

        // Asynchronous reset two cycles into a multiply.
        a = 4'h7;
        b = 4'h7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_busy", {7'd0, busy}, 8'd0);
        check("arst_done", {7'd0, done}, 8'd0);
        check("arst_product", product, 8'h00);
        $display("txn async_reset busy=%0d done=%0d product=%0h", busy, done, product);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_idle_busy", {7'd0, busy}, 8'd0);
        run_mult("post_rst", 4'h2, 4'h3, 8'h06);

        // Back-to-back sweep with start held high; operands scrambled while in flight.
        start = 1'b1;
        for (int p = 0; p < 256; p++) begin
            logic [3:0] av;
            logic [3:0] bv;
            logic [7:0] exp;
            av = 4'(p >> 4);
            bv = 4'(p);
            exp = 8'(av) * 8'(bv);
            a = av;
            b = bv;
            for (int idx = 0; idx < 6; idx++) begin
                @(negedge clk);
                if (idx == 0) begin
                    a = ~av;
                    b = ~bv;
                end
                check("sweep_done", {7'd0, done}, (idx == 4) ? 8'd1 : 8'd0);
                if (idx == 4) begin
                    check("sweep_product", product, exp);
                    $display("txn sweep a=%0d b=%0d product=%0h expected=%0h", av, bv, product, exp);
                end
            end
        end
        start = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seq_mult4
